// File: rtl/aes_ctr_sequencer.sv
// aes_ctr_sequencer: CTR-mode sequencer around an AES core (start/done handshake, XOR, counter increment).
// Optional partial/last-block handling is enabled by defining AES_CTR_PARTIAL_EN.
module aes_ctr_sequencer #(
  parameter int CTR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [127:0]      iv_i,
  input  logic              iv_load_i,
  input  logic [127:0]      data_i,
  input  logic              data_valid_i,
`ifdef AES_CTR_PARTIAL_EN
  input  logic              last_i,
  input  logic [3:0]        len_i,
`endif
  output logic              data_ready_o,
  output logic [127:0]      core_block_o,
  output logic              core_start_o,
  input  logic              core_done_i,
  input  logic [127:0]      core_keystream_i,
  output logic [127:0]      data_o,
  output logic              data_valid_o,
  input  logic              data_ready_i,
  output logic [CTR_W-1:0]  ctr_o,
  output logic              ctr_wrap_o,
  output logic              busy_o
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, OUT} state_t;
  localparam logic [127:0] CTR_MASK = {128{1'b1}} >> (128 - CTR_W);
  state_t state_q, state_d;
  logic [127:0] ctr_q, ctr_d, data_q, data_d, out_q, out_d, keep;
  logic wrap_q, wrap_d, inc_en;
`ifdef AES_CTR_PARTIAL_EN
  logic last_q, last_d;
  logic [3:0] len_q, len_d;
  // byte 0 sits in the top bits, so a length of n keeps the top 8*n bits
  assign keep = (len_q == 4'd0) ? '1 : ~({128{1'b1}} >> (8 * len_q));
  assign inc_en = !last_q;
`else
  assign keep = '1;
  assign inc_en = 1'b1;
`endif
  always_comb begin
    state_d = state_q;
    ctr_d = ctr_q;
    data_d = data_q;
    out_d = out_q;
    wrap_d = wrap_q;
`ifdef AES_CTR_PARTIAL_EN
    last_d = last_q;
    len_d = len_q;
`endif
    case (state_q)
      IDLE: begin
        if (iv_load_i) begin
          ctr_d = iv_i;
          wrap_d = 1'b0;
        end
        if (data_valid_i) begin
          data_d = data_i;
`ifdef AES_CTR_PARTIAL_EN
          last_d = last_i;
          len_d = len_i;
`endif
          state_d = REQ;
        end
      end
      REQ: state_d = WAIT;
      WAIT: if (core_done_i) begin
        out_d = (data_q ^ core_keystream_i) & keep;
        state_d = OUT;
      end
      default: if (data_ready_i) begin
        if (inc_en) begin
          ctr_d = (ctr_q & ~CTR_MASK) | ((ctr_q + 128'd1) & CTR_MASK);
          wrap_d = wrap_q | ((ctr_q & CTR_MASK) == CTR_MASK);
        end
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ctr_q <= '0;
      data_q <= '0;
      out_q <= '0;
      wrap_q <= 1'b0;
`ifdef AES_CTR_PARTIAL_EN
      last_q <= 1'b0;
      len_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      ctr_q <= ctr_d;
      data_q <= data_d;
      out_q <= out_d;
      wrap_q <= wrap_d;
`ifdef AES_CTR_PARTIAL_EN
      last_q <= last_d;
      len_q <= len_d;
`endif
    end
  end
  assign data_ready_o = state_q == IDLE;
  assign core_start_o = state_q == REQ;
  assign data_valid_o = state_q == OUT;
  assign busy_o = state_q != IDLE;
  assign core_block_o = ctr_q;
  assign data_o = out_q;
  assign ctr_o = ctr_q[CTR_W-1:0];
  assign ctr_wrap_o = wrap_q;
endmodule

// File: tb/tb_aes_ctr_sequencer.sv
// tb_aes_ctr_sequencer: randomized self-checking bench with a behavioural CTR model and a stub AES core.
module tb_aes_ctr_sequencer;
  logic clk = 0, rst = 1;
  logic [127:0] iv_i = '0, data_i = '0, core_keystream_i = '0;
  logic iv_load_i = 0, data_valid_i = 0, core_done_i = 0, data_ready_i = 0;
  logic last_i = 0;
  logic [3:0] len_i = '0;
  logic data_ready_o, core_start_o, data_valid_o, ctr_wrap_o, busy_o;
  logic [127:0] core_block_o, data_o;
  logic [31:0] ctr_o;
  logic [127:0] m_ctr;
  logic m_wrap;
  int checks = 0, errors = 0;

  aes_ctr_sequencer #(.CTR_W(32)) dut (
    .clk(clk), .rst(rst), .iv_i(iv_i), .iv_load_i(iv_load_i),
    .data_i(data_i), .data_valid_i(data_valid_i),
`ifdef AES_CTR_PARTIAL_EN
    .last_i(last_i), .len_i(len_i),
`endif
    .data_ready_o(data_ready_o), .core_block_o(core_block_o), .core_start_o(core_start_o),
    .core_done_i(core_done_i), .core_keystream_i(core_keystream_i),
    .data_o(data_o), .data_valid_o(data_valid_o), .data_ready_i(data_ready_i),
    .ctr_o(ctr_o), .ctr_wrap_o(ctr_wrap_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_vld"}, data_valid_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_rdy"}, data_ready_o, 1);
    chk({tag, "_ctr"}, ctr_o, m_ctr[31:0]);
    chk({tag, "_blk"}, core_block_o, m_ctr);
    chk({tag, "_wrap"}, ctr_wrap_o, m_wrap);
  endtask

  task automatic load_iv(input logic [127:0] iv);
    iv_i = iv;
    iv_load_i = 1;
    @(negedge clk);
    iv_load_i = 0;
    m_ctr = iv;
    m_wrap = 0;
    chk_idle("load");
  endtask

  task automatic run_block(input logic [127:0] d, input logic [127:0] ks, input int dly, input int hold,
                           input bit ld_req, input bit ld_wait, input logic [127:0] iv,
                           input bit last, input logic [3:0] len);
    logic [127:0] exp;
    data_i = d;
    data_valid_i = 1;
    last_i = last;
    len_i = len;
    if (ld_req) begin
      iv_i = iv;
      iv_load_i = 1;
    end
    @(negedge clk);
    data_valid_i = 0;
    iv_load_i = 0;
    if (ld_req) begin
      m_ctr = iv;
      m_wrap = 0;
    end
    chk("start", core_start_o, 1);
    chk("busy", busy_o, 1);
    chk("rdy_low", data_ready_o, 0);
    chk("req_blk", core_block_o, m_ctr);
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      chk("start_once", core_start_o, 0);
      chk("no_vld", data_valid_o, 0);
      iv_i = {$urandom, $urandom, $urandom, $urandom};
      iv_load_i = ld_wait;
    end
    core_keystream_i = ks;
    core_done_i = 1;
    @(negedge clk);
    core_done_i = 0;
    iv_load_i = 0;
    exp = d ^ ks;
    for (int b = 0; b < 16; b++)
      if (len != 0 && b >= len) exp[127 - 8 * b -: 8] = 8'h00;
    chk("vld", data_valid_o, 1);
    chk("dout", data_o, exp);
    chk("ctr_held", ctr_o, m_ctr[31:0]);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_vld", data_valid_o, 1);
      chk("hold_dout", data_o, exp);
      chk("hold_rdy", data_ready_o, 0);
      chk("hold_ctr", ctr_o, m_ctr[31:0]);
    end
    data_ready_i = 1;
    @(negedge clk);
    data_ready_i = 0;
    if (!last) begin
      if (m_ctr[31:0] == 32'hFFFF_FFFF) m_wrap = 1;
      m_ctr[31:0] = m_ctr[31:0] + 32'd1;
    end
    chk_idle("post");
  endtask

  initial begin
    logic [127:0] iv, d;
    bit last;
    m_ctr = '0;
    m_wrap = 0;
    repeat (2) @(negedge clk);
    chk("rst_dout", data_o, 0);
    chk("rst_start", core_start_o, 0);
    chk_idle("rst");
    rst = 0;
    @(negedge clk);
    load_iv(128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF);
    run_block(128'h6BC1BEE22E409F96E93D7E117393172A, '1, 5, 4, 0, 0, '0, 0, 0);
    chk("basic_ctr", ctr_o, 32'hFCFDFF00);
    load_iv(128'h0123456789ABCDEF01234567FFFFFFFF);
    run_block({4{$urandom}}, {4{$urandom}}, 2, 1, 0, 1, '0, 0, 0);
    chk("wrap_flag", ctr_wrap_o, 1);
    chk("wrap_upper", core_block_o, 128'h0123456789ABCDEF0123456700000000);
    load_iv(128'h00000000000000000000000012345678);
    core_done_i = 1;
    @(negedge clk);
    core_done_i = 0;
    @(negedge clk);
    chk_idle("spurious");
    run_block({4{$urandom}}, {4{$urandom}}, 3, 0, 1, 0, 128'hAAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000_1111, 0, 0);
`ifdef AES_CTR_PARTIAL_EN
    run_block(128'h6BC1BEE22E409F96E93D7E117393172A, '1, 5, 1, 0, 0, '0, 1, 4'd5);
    chk("part_dout", data_o, 128'h943E411DD1000000_0000000000000000);
`endif
    for (int n = 0; n < 25; n++) begin
      iv = {$urandom, $urandom, $urandom, ($urandom % 3 == 0) ? 32'hFFFF_FFFF : $urandom};
      d = {$urandom, $urandom, $urandom, $urandom};
`ifdef AES_CTR_PARTIAL_EN
      last = $urandom % 2 == 1;
`else
      last = 0;
`endif
      run_block(d, {$urandom, $urandom, $urandom, $urandom}, $urandom_range(1, 6), $urandom_range(0, 3),
                $urandom % 3 == 0, $urandom % 3 == 0, iv, last, last ? 4'($urandom) : 4'd0);
    end
    data_i = {4{$urandom}};
    data_valid_i = 1;
    @(negedge clk);
    data_valid_i = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    m_ctr = '0;
    m_wrap = 0;
    chk("arst_dout", data_o, 0);
    chk("arst_start", core_start_o, 0);
    chk_idle("arst");
    rst = 0;
    @(negedge clk);
    core_keystream_i = {4{$urandom}};
    core_done_i = 1;
    @(negedge clk);
    core_done_i = 0;
    @(negedge clk);
    chk("late_done_dout", data_o, 0);
    chk_idle("late_done");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/aes_ctr_sequencer.md
Name: aes_ctr_sequencer

Overview:
- CTR-mode front/back end wrapped around the AES-256 cipher core.
- Accepts 128-bit data blocks, issues the current counter block to the core with a start/done handshake, and XORs the returned keystream with the held data block.
- Presents the result downstream, then increments the counter.
- The same block serves encryption and decryption, because CTR keystream generation is identical in both directions.

Parameters:
- CTR_W, 32: width of the incrementing counter field, taken from the low bits of the 128-bit counter block. Legal range is 8..128.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- iv_i  in  128  initial counter block (nonce || counter)
- iv_load_i  in  1  one-cycle pulse; loads iv_i into the counter register
- data_i  in  128  input plaintext/ciphertext block
- data_valid_i  in  1  input block valid
- data_ready_o  out  1  block can accept input
- core_block_o  out  128  counter block presented to the AES core
- core_start_o  out  1  one-cycle start pulse to the core
- core_done_i  in  1  one-cycle pulse; core_keystream_i is valid in that cycle
- core_keystream_i  in  128  encrypted counter block from the core
- data_o  out  128  output block, equal to held data XOR keystream
- data_valid_o  out  1  output valid
- data_ready_i  in  1  downstream ready
- ctr_o  out  CTR_W  current counter field
- ctr_wrap_o  out  1  sticky flag: counter field wrapped
- busy_o  out  1  high whenever state is not IDLE

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset values:
  - state = IDLE; counter register = 0; data/keystream holding registers = 0.
  - data_o = 0; data_valid_o = 0; core_start_o = 0; ctr_wrap_o = 0; busy_o = 0.
  - data_ready_o = 1.
  - A reset asserted mid-operation aborts the block in flight with no output. Any later core_done_i is ignored while the state is IDLE.
- core_block_o is driven continuously from the counter register.
- States and transitions:
  - IDLE: data_ready_o = 1. On data_valid_i && data_ready_o, capture data_i and go to REQ.
  - REQ: core_start_o = 1 for exactly this one cycle, then go to WAIT.
  - WAIT: on core_done_i, register data XOR core_keystream_i into data_o and go to OUT. No timeout.
  - OUT: data_valid_o = 1; data_o is held stable until data_ready_i.
    - On the handshake: low CTR_W bits of the counter increment mod 2^CTR_W; upper 128-CTR_W bits are unchanged; go to IDLE.
    - If the increment wraps from all-ones to 0, set ctr_wrap_o.
- Latency: input accepted at cycle N gives core_start_o at N+1. core_done_i at cycle D gives data_valid_o at D+1. Throughput is one block in flight.
- iv_load_i:
  - Honoured only in IDLE: loads iv_i and clears ctr_wrap_o.
  - If it coincides with an input handshake in IDLE, the load wins. That block uses the newly loaded iv_i, because the counter register updates at the same edge as REQ is entered.
  - Ignored in all other states.
- core_done_i outside WAIT is ignored.
- ctr_o = counter[CTR_W-1:0]. busy_o = (state != IDLE).

Optional Feature:
- Macro: AES_CTR_PARTIAL_EN.
- When defined, two extra inputs are sampled with data_i at the input handshake:
  - last_i (1): marks the final block of a message.
  - len_i (4): valid byte count, where 0 means 16.
- Byte 0 is data bits [127:120]. Output bytes at index >= len are forced to 0.
- When last_i was set, the counter does not increment on the output handshake, and a partial block never sets ctr_wrap_o.
- When the macro is undefined, these ports do not exist; every block is a full 16 bytes and always increments the counter.

Test Plan:
- Basic block, with a stub core returning keystream 128'hFFFF...FF five cycles after start:
  - Stimulus: iv_load_i with iv 128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF, then data 128'h6BC1BEE22E409F96E93D7E117393172A.
  - Required: core_block_o equals the iv; data_o = 128'h943E411DD1BF6069.16C281EE8C6CE8D5 (i.e. 128'h943E411DD1BF606916C281EE8C6CE8D5).
  - Required: ctr_o goes from FCFDFEFF to FCFDFF00 after the output handshake; upper 96 bits unchanged.
- Timing: accept at cycle 10 -> core_start_o high only at cycle 11. core_done_i at 16 -> data_valid_o at 17.
  - Hold data_ready_i = 0 for 4 cycles -> data_o stable; data_ready_o = 0; ctr_o unchanged.
- Wrap: CTR_W = 32, iv low word FFFFFFFF, one block -> ctr_o = 0, ctr_wrap_o = 1, bits [127:32] unchanged. A subsequent iv_load_i in IDLE -> ctr_wrap_o = 0.
- Ignored inputs:
  - iv_load_i pulsed in WAIT -> counter unchanged.
  - Spurious core_done_i in IDLE -> no data_valid_o.
  - Reset asserted in WAIT -> all outputs at reset values next cycle, and a later core_done_i produces no output.
- AES_CTR_PARTIAL_EN: len_i = 5, last_i = 1, keystream all-ones, data 128'h6BC1BEE22E409F96E93D7E117393172A.
  - Required: data_o = 128'h943E411DD1000000_0000000000000000.
  - Required: ctr_o unchanged after the handshake.
